// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
// mem_bus_pkg : shared encodings and helpers for the data-side bus controller
// Rev 1.0
// ============================================================================
package mem_bus_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   localparam logic [3:0] OFF_LED = 4'h0;
   localparam logic [3:0] OFF_HEX = 4'h4;
   localparam logic [3:0] OFF_SW  = 4'h8;
   localparam logic [3:0] OFF_KEY = 4'hC;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RD_WAIT = 2'd1,
      S_RESP    = 2'd2,
      S_ERR     = 2'd3
   } state_e;

   // Little-endian lane enables for an aligned access of the given size.
   function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SZ_B:    lane_be = 4'b0001 << off;
         SZ_H:    lane_be = off[1] ? 4'b1100 : 4'b0011;
         SZ_W:    lane_be = 4'b1111;
         default: lane_be = 4'b0000;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_controller_mmio_regs.sv
`default_nettype none
// ============================================================================
// mmio_regs : LED/HEX registers, SW/KEY read mux and read-only write detect
// Rev 1.0
// ============================================================================
module mmio_regs
   import mem_bus_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en_i,
   input  logic [3:0]  off_i,
   input  logic [31:0] wdata_i,
   input  logic [9:0]  sw_i,
   input  logic [3:0]  key_i,
   output logic [9:0]  led_o,
   output logic [31:0] hex_o,
   output logic [31:0] rd_data_o,
   output logic        ro_o
);

   logic [9:0]  led_q;
   logic [31:0] hex_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         led_q <= 10'd0;
         hex_q <= 32'd0;
      end else if (wr_en_i) begin
         if (off_i == OFF_LED) led_q <= wdata_i[9:0];
         if (off_i == OFF_HEX) hex_q <= wdata_i;
      end
   end

   // Keys are active-low on the board; software sees a pressed key as 1.
   always_comb begin
      rd_data_o = 32'd0;
      case (off_i)
         OFF_LED: rd_data_o = {22'd0, led_q};
         OFF_HEX: rd_data_o = hex_q;
         OFF_SW:  rd_data_o = {22'd0, sw_i};
         OFF_KEY: rd_data_o = {28'd0, ~key_i};
         default: rd_data_o = 32'd0;
      endcase
   end

   assign ro_o  = (off_i == OFF_SW) || (off_i == OFF_KEY);
   assign led_o = led_q;
   assign hex_o = hex_q;

endmodule
`default_nettype wire

// File: rtl/mem_bus_controller.sv
`default_nettype none
// ============================================================================
// mem_bus_controller : single-outstanding load/store bus to word RAM and MMIO
// Rev 1.0
// ============================================================================
module mem_bus_controller
   import mem_bus_pkg::*;
#(
   parameter int          RAM_AW    = 10,
   parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [1:0]        size,
   input  logic              uns,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              done,
   output logic              err,
   output logic              busy,
   output logic [RAM_AW-1:0] ram_addr,
   output logic              ram_we,
   output logic [3:0]        ram_be,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   input  logic [9:0]        sw_in,
   input  logic [3:0]        key_in,
   output logic [9:0]        led_out,
   output logic [31:0]       hex_val
);

   state_e            state_q, state_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [31:0]       dat_q, dat_d;
   logic [31:0]       ram_wdata_q, ram_wdata_d;
   logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
   logic [3:0]        ram_be_q, ram_be_d;
   logic [1:0]        size_q, size_d;
   logic [1:0]        off_q, off_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              busy_q, busy_d;
   logic              ram_we_q, ram_we_d;
   logic              uns_q, uns_d;
   logic              ramld_q, ramld_d;

   logic [31:0] mmio_rel, mmio_rd, store_rep, load_fmt;
   logic [15:0] lane_h;
   logic [7:0]  lane_b;
   logic        is_ram, is_mmio, aligned, acc_err, accept, mmio_wr, mmio_ro;

   // Subtraction keeps the window test free of a wide compare against the base.
   assign mmio_rel = addr - MMIO_BASE;
   assign is_mmio  = (mmio_rel[31:4] == 28'd0);
   assign is_ram   = (addr[31:RAM_AW+2] == '0);

   always_comb begin
      case (size)
         SZ_B:    aligned = 1'b1;
         SZ_H:    aligned = ~addr[0];
         SZ_W:    aligned = (addr[1:0] == 2'b00);
         default: aligned = 1'b0;
      endcase
   end

   assign acc_err = ~aligned | ~(is_ram | is_mmio)
                  | (is_mmio & ((size != SZ_W) | (we & mmio_ro)));
   // The done cycle is already IDLE, so a request there must not be taken.
   assign accept  = (state_q == S_IDLE) & req & ~done_q;
   assign mmio_wr = accept & is_mmio & we & ~acc_err;

   always_comb begin
      case (size)
         SZ_B:    store_rep = {4{wdata[7:0]}};
         SZ_H:    store_rep = {2{wdata[15:0]}};
         default: store_rep = wdata;
      endcase
   end

   assign lane_h = off_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
   assign lane_b = off_q[0] ? lane_h[15:8]     : lane_h[7:0];

   always_comb begin
      case (size_q)
         SZ_B:    load_fmt = uns_q ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
         SZ_H:    load_fmt = uns_q ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
         default: load_fmt = ram_rdata;
      endcase
   end

   mmio_regs u_mmio (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (mmio_wr),
      .off_i     (mmio_rel[3:0]),
      .wdata_i   (wdata),
      .sw_i      (sw_in),
      .key_i     (key_in),
      .led_o     (led_out),
      .hex_o     (hex_val),
      .rd_data_o (mmio_rd),
      .ro_o      (mmio_ro)
   );

   always_comb begin
      state_d     = state_q;
      rdata_d     = rdata_q;
      dat_d       = dat_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      busy_d      = busy_q;
      ram_we_d    = 1'b0;
      ram_be_d    = 4'b0000;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      size_d      = size_q;
      off_d       = off_q;
      uns_d       = uns_q;
      ramld_d     = ramld_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               size_d  = size;
               off_d   = addr[1:0];
               uns_d   = uns;
               ramld_d = is_ram & ~we & ~acc_err;
               busy_d  = 1'b1;
               rdata_d = 32'd0;
               dat_d   = 32'd0;
               if (acc_err) begin
                  state_d = S_ERR;
               end else if (is_ram) begin
                  ram_addr_d = addr[RAM_AW+1:2];
                  if (we) begin
                     ram_we_d    = 1'b1;
                     ram_be_d    = lane_be(size, addr[1:0]);
                     ram_wdata_d = store_rep;
                     state_d     = S_RESP;
                  end else begin
                     state_d = S_RD_WAIT;
                  end
               end else begin
                  if (!we) dat_d = mmio_rd;
                  state_d = S_RESP;
               end
            end
         end
         S_RD_WAIT: state_d = S_RESP;
         // RAM read data lands during RESP, so it is formatted on the way out.
         S_RESP: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            rdata_d = ramld_q ? load_fmt : dat_q;
            state_d = S_IDLE;
         end
         S_ERR: begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            busy_d  = 1'b0;
            rdata_d = 32'd0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         rdata_q     <= 32'd0;
         dat_q       <= 32'd0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_be_q    <= 4'b0000;
         ram_addr_q  <= '0;
         ram_wdata_q <= 32'd0;
         size_q      <= SZ_B;
         off_q       <= 2'b00;
         uns_q       <= 1'b0;
         ramld_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         rdata_q     <= rdata_d;
         dat_q       <= dat_d;
         done_q      <= done_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
         ram_we_q    <= ram_we_d;
         ram_be_q    <= ram_be_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         size_q      <= size_d;
         off_q       <= off_d;
         uns_q       <= uns_d;
         ramld_q     <= ramld_d;
      end
   end

   assign rdata     = rdata_q;
   assign done      = done_q;
   assign err       = err_q;
   assign busy      = busy_q;
   assign ram_we    = ram_we_q;
   assign ram_be    = ram_be_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_controller.sv
`default_nettype none
// ============================================================================
// tb_mem_bus_controller : directed table, corner sequences and random traffic
// Rev 1.0
// ============================================================================
module tb_mem_bus_controller;
   import mem_bus_pkg::*;

   localparam int          RAM_AW = 10;
   localparam logic [31:0] MB     = 32'hFFFF_0000;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              req = 1'b0, we = 1'b0, uns = 1'b0;
   logic [1:0]        size = 2'b00;
   logic [31:0]       addr = 32'd0, wdata = 32'd0;
   logic [31:0]       rdata, ram_wdata, hex_val;
   logic              done, err, busy, ram_we;
   logic [RAM_AW-1:0] ram_addr;
   logic [3:0]        ram_be;
   logic [31:0]       ram_rdata;
   logic [9:0]        sw_in = 10'd0, led_out;
   logic [3:0]        key_in = 4'hF;
   logic              mem_clr = 1'b1;

   int total = 0;
   int bad   = 0;

   logic [31:0] tb_mem [0:(1<<RAM_AW)-1];
   logic [7:0]  ref_mem [0:4095];
   logic [9:0]  ref_led = 10'd0;
   logic [31:0] ref_hex = 32'd0;

   mem_bus_controller #(.RAM_AW(RAM_AW), .MMIO_BASE(MB)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .uns(uns),
      .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .err(err),
      .busy(busy), .ram_addr(ram_addr), .ram_we(ram_we), .ram_be(ram_be),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .sw_in(sw_in),
      .key_in(key_in), .led_out(led_out), .hex_val(hex_val)
   );

   always #5 clk = ~clk;

   // Synchronous-read RAM with byte lanes.
   always @(posedge clk) begin
      logic [31:0] w;
      if (mem_clr) begin
         for (int i = 0; i < (1 << RAM_AW); i++) tb_mem[i] <= 32'd0;
      end else begin
         w = tb_mem[ram_addr];
         for (int i = 0; i < 4; i++) if (ram_be[i]) w[8*i +: 8] = ram_wdata[8*i +: 8];
         if (ram_we) tb_mem[ram_addr] <= w;
      end
      ram_rdata <= tb_mem[ram_addr];
   end

   typedef struct {
      logic        w;
      logic [1:0]  sz;
      logic        u;
      logic [31:0] a;
      logic [31:0] d;
      logic        e;
      logic [31:0] r;
      int          lat;
      logic [3:0]  be;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(input logic w, input logic [1:0] sz, input logic u,
                               input logic [31:0] a, input logic [31:0] d, input logic e,
                               input logic [31:0] r, input int lat, input logic [3:0] be);
      vec_t v;
      v.w = w; v.sz = sz; v.u = u; v.a = a; v.d = d; v.e = e; v.r = r; v.lat = lat; v.be = be;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: byte-addressed memory plus the two writable registers.
   task automatic ref_op(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic e, output logic [31:0] r, output int lat);
      int     n;
      longint v;
      n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      e   = 1'b0;
      r   = 32'd0;
      lat = 2;
      if (sz == 2'd3 || (a % n) != 0) begin
         e = 1'b1;
      end else if (a < 32'd4096) begin
         if (w) begin
            for (int i = 0; i < n; i++) ref_mem[a + i] = 8'(d >> (8 * i));
         end else begin
            v = 0;
            for (int i = n - 1; i >= 0; i--) v = v * 256 + ref_mem[a + i];
            if (!u && n < 4 && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
            r   = 32'(v);
            lat = 3;
         end
      end else if (a >= MB && (a - MB) < 32'd16) begin
         if (n != 4) e = 1'b1;
         else begin
            case (a - MB)
               32'd0:   if (w) ref_led = d[9:0]; else r = {22'd0, ref_led};
               32'd4:   if (w) ref_hex = d;      else r = ref_hex;
               32'd8:   if (w) e = 1'b1;         else r = 32'(sw_in);
               default: if (w) e = 1'b1;         else r = 32'(15 - key_in);
            endcase
         end
      end else begin
         e = 1'b1;
      end
      if (e) begin
         r   = 32'd0;
         lat = 2;
      end
   endtask

   // One request, held for a single cycle; waits a bounded time for done.
   task automatic txn(input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic e, output int lat,
                      output int nwe, output logic [3:0] be, output logic b1);
      @(negedge clk);
      req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
      lat = 0; nwe = 0; be = 4'd0; b1 = 1'b0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            req = 1'b0;
            b1  = busy;
         end
         if (ram_we) begin
            nwe++;
            be = ram_be;
         end
      end while (!done && lat < 8);
      rd = rdata;
      e  = err;
   endtask

   task automatic mcheck(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
      logic [31:0] rd, er;
      logic        e, ee, b1;
      logic [3:0]  be, eb;
      int          lat, el, nwe, n;
      txn(w, sz, u, a, d, rd, e, lat, nwe, be, b1);
      ref_op(w, sz, u, a, d, ee, er, el);
      n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      eb = 4'd0;
      if (w && !ee && a < 32'd4096) for (int i = 0; i < n; i++) eb[(a % 4) + i] = 1'b1;
      chk("rand_latency", lat, el);
      chk("rand_err", e, ee);
      if (!w || ee) chk("rand_rdata", rd, er);
      chk("rand_we_count", nwe, (eb != 4'd0) ? 1 : 0);
      chk("rand_ram_be", be, eb);
      chk("rand_busy", b1, 1);
      chk("rand_led", led_out, ref_led);
      chk("rand_hex", hex_val, ref_hex);
   endtask

   initial begin
      logic [31:0] rd, er, a, d;
      logic        e, ee, b1, w, u;
      logic [3:0]  be;
      logic [1:0]  sz;
      int          lat, el, nwe, ndone, sel, r;

      for (int i = 0; i < 4096; i++) ref_mem[i] = 8'd0;

      // Reset values
      repeat (3) @(negedge clk);
      mem_clr = 1'b0;
      chk("rst_rdata", rdata, 0);
      chk("rst_ctl", {done, err, busy, ram_we, ram_be}, 0);
      chk("rst_ram_addr", 32'(ram_addr), 0);
      chk("rst_ram_wdata", ram_wdata, 0);
      chk("rst_led", 32'(led_out), 0);
      chk("rst_hex", hex_val, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_ctl", {done, err, busy, ram_we, ram_be}, 0);

      // Directed table
      sw_in  = 10'h155;
      key_in = 4'b1010;
      tv.push_back(mk(1, SZ_W, 0, 32'h10,       32'hDEADBEEF, 0, 32'h0,        2, 4'hF));
      tv.push_back(mk(0, SZ_W, 0, 32'h10,       32'h0,        0, 32'hDEADBEEF, 3, 4'h0));
      tv.push_back(mk(1, SZ_B, 0, 32'h13,       32'h80,       0, 32'h0,        2, 4'h8));
      tv.push_back(mk(0, SZ_B, 0, 32'h13,       32'h0,        0, 32'hFFFFFF80, 3, 4'h0));
      tv.push_back(mk(0, SZ_B, 1, 32'h13,       32'h0,        0, 32'h00000080, 3, 4'h0));
      tv.push_back(mk(0, SZ_H, 0, 32'h11,       32'h0,        1, 32'h0,        2, 4'h0));
      tv.push_back(mk(1, SZ_W, 0, 32'h80000000, 32'h1,        1, 32'h0,        2, 4'h0));
      tv.push_back(mk(1, SZ_W, 0, MB,           32'h2A5,      0, 32'h0,        2, 4'h0));
      tv.push_back(mk(0, SZ_W, 0, MB + 8,       32'h0,        0, 32'h155,      2, 4'h0));
      tv.push_back(mk(1, SZ_W, 0, MB + 8,       32'h5,        1, 32'h0,        2, 4'h0));
      tv.push_back(mk(0, SZ_H, 1, 32'h12,       32'h0,        0, 32'h000080AD, 3, 4'h0));
      tv.push_back(mk(0, SZ_H, 0, 32'h12,       32'h0,        0, 32'hFFFF80AD, 3, 4'h0));
      tv.push_back(mk(0, 2'd3, 0, 32'h20,       32'h0,        1, 32'h0,        2, 4'h0));
      tv.push_back(mk(0, SZ_W, 0, MB + 12,      32'h0,        0, 32'h5,        2, 4'h0));
      tv.push_back(mk(1, SZ_H, 0, 32'h22,       32'h1234,     0, 32'h0,        2, 4'hC));
      tv.push_back(mk(0, SZ_W, 0, 32'h20,       32'h0,        0, 32'h12340000, 3, 4'h0));
      tv.push_back(mk(1, SZ_W, 0, MB + 4,       32'hCAFEF00D, 0, 32'h0,        2, 4'h0));
      tv.push_back(mk(0, SZ_W, 0, MB + 4,       32'h0,        0, 32'hCAFEF00D, 2, 4'h0));
      tv.push_back(mk(0, SZ_W, 0, MB + 16,      32'h0,        1, 32'h0,        2, 4'h0));
      tv.push_back(mk(0, SZ_W, 0, 32'h1000,     32'h0,        1, 32'h0,        2, 4'h0));
      tv.push_back(mk(1, SZ_B, 0, 32'hFFF,      32'h5A,       0, 32'h0,        2, 4'h8));
      tv.push_back(mk(0, SZ_W, 0, 32'hFFC,      32'h0,        0, 32'h5A000000, 3, 4'h0));
      tv.push_back(mk(0, SZ_B, 0, MB,           32'h0,        1, 32'h0,        2, 4'h0));
      tv.push_back(mk(0, SZ_W, 0, MB,           32'h0,        0, 32'h000002A5, 2, 4'h0));
      tv.push_back(mk(1, SZ_W, 0, 32'h12,       32'h77777777, 1, 32'h0,        2, 4'h0));
      tv.push_back(mk(0, SZ_W, 0, 32'h10,       32'h0,        0, 32'h80ADBEEF, 3, 4'h0));
      foreach (tv[k]) begin
         txn(tv[k].w, tv[k].sz, tv[k].u, tv[k].a, tv[k].d, rd, e, lat, nwe, be, b1);
         ref_op(tv[k].w, tv[k].sz, tv[k].u, tv[k].a, tv[k].d, ee, er, el);
         chk($sformatf("vec%0d_latency", k), lat, tv[k].lat);
         chk($sformatf("vec%0d_err", k), e, tv[k].e);
         if (!tv[k].w || tv[k].e) chk($sformatf("vec%0d_rdata", k), rd, tv[k].r);
         chk($sformatf("vec%0d_we_count", k), nwe, (tv[k].be != 4'd0) ? 1 : 0);
         chk($sformatf("vec%0d_ram_be", k), be, tv[k].be);
         chk($sformatf("vec%0d_busy", k), b1, 1);
         chk($sformatf("vec%0d_led", k), led_out, ref_led);
         chk($sformatf("vec%0d_hex", k), hex_val, ref_hex);
      end

      // Request held into the cycle after accept: one store, one done
      @(negedge clk);
      req = 1'b1; we = 1'b1; size = SZ_W; uns = 1'b0; addr = 32'h40; wdata = 32'h11223344;
      ndone = 0; nwe = 0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (c == 2) req = 1'b0;
         if (done) ndone++;
         if (ram_we) nwe++;
      end
      chk("dup_req_done_count", ndone, 1);
      chk("dup_req_we_count", nwe, 1);
      ref_op(1'b1, SZ_W, 1'b0, 32'h40, 32'h11223344, ee, er, el);
      mcheck(1'b0, SZ_W, 1'b0, 32'h40, 32'h0);

      // Reset asserted together with a store request: the write must not happen
      @(negedge clk);
      rst = 1'b0; req = 1'b1; we = 1'b1; size = SZ_W; addr = 32'h40; wdata = 32'hBAD0BAD0;
      nwe = 0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         if (c == 1) req = 1'b0;
         if (ram_we) nwe++;
      end
      chk("rst_store_we_count", nwe, 0);
      @(negedge clk);
      rst = 1'b1;
      ref_led = 10'd0;
      ref_hex = 32'd0;
      mcheck(1'b0, SZ_W, 1'b0, 32'h40, 32'h0);

      // Reset during RD_WAIT
      mcheck(1'b1, SZ_W, 1'b0, MB, 32'h3C3);
      mcheck(1'b1, SZ_W, 1'b0, MB + 4, 32'h0BADF00D);
      @(negedge clk);
      req = 1'b1; we = 1'b0; size = SZ_W; addr = 32'h10;
      @(negedge clk);
      req = 1'b0;
      chk("rdwait_busy_before_rst", busy, 1);
      rst = 1'b0;
      #1;
      chk("rdwait_rst_busy", busy, 0);
      chk("rdwait_rst_done", done, 0);
      chk("rdwait_rst_led", 32'(led_out), 0);
      chk("rdwait_rst_hex", hex_val, 0);
      ndone = 0;
      repeat (3) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("rdwait_rst_done_count", ndone, 0);
      rst = 1'b1;
      ref_led = 10'd0;
      ref_hex = 32'd0;
      mcheck(1'b0, SZ_W, 1'b0, 32'h10, 32'h0);

      // Random traffic against the model
      for (int k = 0; k < 150; k++) begin
         w   = 1'($urandom_range(0, 1));
         u   = 1'($urandom_range(0, 1));
         r   = $urandom_range(0, 9);
         sz  = (r < 3) ? SZ_B : (r < 6) ? SZ_H : (r < 9) ? SZ_W : 2'd3;
         sel = $urandom_range(0, 9);
         if (sel < 6)       a = $urandom_range(0, 255);
         else if (sel < 8)  a = MB + $urandom_range(0, 19);
         else if (sel == 8) a = $urandom_range(4080, 4100);
         else               a = $urandom;
         if (sel >= 6 && sel < 8 && $urandom_range(0, 3) != 0) sz = SZ_W;
         if ($urandom_range(0, 3) != 0) begin
            if (sz == SZ_H) a = a & ~32'd1;
            if (sz == SZ_W) a = a & ~32'd3;
         end
         d      = $urandom;
         sw_in  = 10'($urandom);
         key_in = 4'($urandom);
         mcheck(w, sz, u, a, d);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
